// File: rtl/keypad_pkg.sv
// Shared types and helpers for the debounced keypad encoder.
package keypad_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StDebounce,
        StPressed,
        StRelease
    } state_e;

    // Bit 0 is key "0"; the remaining bits count down so the top bit is key "1".
    function automatic int unsigned idx_to_code(input int unsigned idx,
                                                input int unsigned num_keys);
        int unsigned code;
        if (idx == 0) begin
            code = 0;
        end else begin
            code = num_keys - idx;
        end
        return code;
    endfunction

    // Debounce and repeat counters share one width; floor of 2 keeps it at least 1 bit.
    function automatic int unsigned cnt_width(input int unsigned deb_cycles,
                                              input int unsigned rep_cycles);
        int unsigned m;
        m = deb_cycles;
        if (rep_cycles > m) begin
            m = rep_cycles;
        end
        if (m < 2) begin
            m = 2;
        end
        return $clog2(m);
    endfunction

endpackage

// File: rtl/keypad_prio_core.sv
// Combinational resolver from a raw key vector to a candidate code and a qualifier.
module keypad_prio_core
    import keypad_pkg::*;
#(
    parameter int unsigned NUM_KEYS   = 10,
    parameter int unsigned CODE_W     = 4,
    parameter int unsigned MULTI_MODE = 0
) (
    input  logic [NUM_KEYS-1:0] keypad_i,
    output logic [CODE_W-1:0]   code_o,
    output logic                cand_ok_o
);

    logic any_set;
    logic multi_set;

    // Later (higher-index) bits overwrite earlier ones, giving highest-index priority.
    always_comb begin
        code_o    = '0;
        any_set   = 1'b0;
        multi_set = 1'b0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            if (keypad_i[i]) begin
                if (any_set) begin
                    multi_set = 1'b1;
                end
                any_set = 1'b1;
                code_o  = CODE_W'(idx_to_code(i, NUM_KEYS));
            end
        end
        cand_ok_o = any_set & ((MULTI_MODE != 0) | ~multi_set);
    end

endmodule

// File: rtl/keypad_encoder.sv
// Debounced N-key keypad encoder: candidate resolve, stable-count debounce,
// registered code with active-low valid, press strobe and optional auto-repeat.
module keypad_encoder
    import keypad_pkg::*;
#(
    parameter int unsigned NUM_KEYS        = 10,
    parameter int unsigned CODE_W          = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned REPEAT_CYCLES   = 0,
    parameter int unsigned MULTI_MODE      = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enablen,
    input  logic [NUM_KEYS-1:0] keypad,
    output logic [CODE_W-1:0]   D,
    output logic                validn,
    output logic                key_strobe,
    output logic                busy
);

    localparam int unsigned     CntW    = cnt_width(DEBOUNCE_CYCLES, REPEAT_CYCLES);
    localparam logic [CntW-1:0] DebLast = CntW'((DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0);
    localparam logic [CntW-1:0] RepLast = CntW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

    if (CODE_W < $clog2(NUM_KEYS)) begin : g_bad_code_w
        $error("keypad_encoder: CODE_W too narrow for NUM_KEYS");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("keypad_encoder: DEBOUNCE_CYCLES must be at least 1");
    end

    state_e              state_q, state_d;
    logic [NUM_KEYS-1:0] ref_q, ref_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [CntW-1:0]     rep_q, rep_d;
    logic [CODE_W-1:0]   d_q, d_d;
    logic                validn_q, validn_d;
    logic                strobe_q, strobe_d;

    logic [CODE_W-1:0]   cand_code;
    logic                cand_ok;
    logic                ref_match;
    logic                keypad_clear;

    keypad_prio_core #(
        .NUM_KEYS   (NUM_KEYS),
        .CODE_W     (CODE_W),
        .MULTI_MODE (MULTI_MODE)
    ) u_prio_core (
        .keypad_i  (keypad),
        .code_o    (cand_code),
        .cand_ok_o (cand_ok)
    );

    assign ref_match    = (keypad == ref_q);
    assign keypad_clear = (keypad == '0);

    always_comb begin
        state_d  = state_q;
        ref_d    = ref_q;
        cnt_d    = cnt_q;
        rep_d    = rep_q;
        d_d      = d_q;
        validn_d = validn_q;
        strobe_d = 1'b0;

        if (!enablen) begin
            // Oven running: drop any key in progress but keep the last code visible.
            state_d  = StIdle;
            cnt_d    = '0;
            rep_d    = '0;
            validn_d = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cand_ok) begin
                        ref_d   = keypad;
                        cnt_d   = '0;
                        state_d = StDebounce;
                    end
                end
                StDebounce: begin
                    if (!ref_match) begin
                        state_d = StIdle;
                    end else if (cnt_q == DebLast) begin
                        state_d  = StPressed;
                        d_d      = cand_code;
                        validn_d = 1'b0;
                        strobe_d = 1'b1;
                        rep_d    = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StPressed: begin
                    if (!ref_match) begin
                        state_d  = StRelease;
                        validn_d = 1'b1;
                        cnt_d    = '0;
                    end else if (REPEAT_CYCLES > 0) begin
                        if (rep_q == RepLast) begin
                            strobe_d = 1'b1;
                            rep_d    = '0;
                        end else begin
                            rep_d = rep_q + 1'b1;
                        end
                    end
                end
                StRelease: begin
                    if (!keypad_clear) begin
                        cnt_d = '0;
                    end else if (cnt_q == DebLast) begin
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            ref_q    <= '0;
            cnt_q    <= '0;
            rep_q    <= '0;
            d_q      <= '0;
            validn_q <= 1'b1;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ref_q    <= ref_d;
            cnt_q    <= cnt_d;
            rep_q    <= rep_d;
            d_q      <= d_d;
            validn_q <= validn_d;
            strobe_q <= strobe_d;
        end
    end

    assign D          = d_q;
    assign validn     = validn_q;
    assign key_strobe = strobe_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: doc/keypad_encoder.md
# keypad_encoder

Parametrised, debounced keypad encoder for the microwave front panel; successor to the single-cycle combinational key encoder. Samples an N-key one-hot keypad, resolves multiple keys by a selectable mode, and qualifies each key with a stable-count debounce. It then presents a registered BCD-style code with an active-low valid and a one-cycle press strobe, with optional auto-repeat. Sits between the raw keypad pins (already synchronised) and the time-entry register of the controller.

## Interface
- NUM_KEYS, 10: keypad width; bit i maps to code (i==0 ? 0 : NUM_KEYS-i), so for 10 keys bit9→1 … bit1→9, bit0→0
- CODE_W, 4: code width; must satisfy 2^CODE_W ≥ NUM_KEYS (elaboration error otherwise)
- DEBOUNCE_CYCLES, 16: consecutive stable samples required for press and for release; minimum 1
- REPEAT_CYCLES, 0: auto-repeat period while held; 0 disables repeat
- MULTI_MODE, 0: 0 = reject any non-one-hot vector; 1 = highest-index set bit wins
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- enablen  input  1  active-low keypad enable; high = oven idle, entry allowed
- keypad  input  NUM_KEYS  synchronised key lines, active-high
- D  output  CODE_W  registered key code; holds last accepted code when invalid
- validn  output  1  active-low; 0 while a debounced key is held
- key_strobe  output  1  one-cycle pulse per accepted press and per repeat
- busy  output  1  high in any state other than IDLE

## Operation
- Candidate: combinational (code, cand_ok) from keypad per MULTI_MODE. All-zero gives cand_ok=0. In mode 0, more than one bit set gives cand_ok=0.
- FSM states: IDLE, DEBOUNCE, PRESSED, RELEASE.
- IDLE: if enablen=1 and cand_ok, latch keypad vector into ref, clear cnt, go to DEBOUNCE.
- DEBOUNCE: keypad≠ref → IDLE. keypad=ref and cnt=DEBOUNCE_CYCLES-1 → PRESSED, load D=code, validn=0, key_strobe=1, clear rep. Otherwise cnt+1.
- PRESSED: keypad≠ref (release or change) → RELEASE, validn=1, clear cnt. Otherwise, if REPEAT_CYCLES>0: rep=REPEAT_CYCLES-1 → key_strobe=1 and rep=0, else rep+1.
- RELEASE: keypad≠0 clears cnt. keypad=0 with cnt=DEBOUNCE_CYCLES-1 → IDLE. Otherwise cnt+1. No new press is accepted until IDLE is reached.
- enablen=0 in any state: next state IDLE, counters cleared, validn=1, key_strobe=0, D holds.
- Reset: state IDLE, D=0, validn=1, key_strobe=0, busy=0, counters and ref 0.
- Counter width: clog2(max(DEBOUNCE_CYCLES, REPEAT_CYCLES, 2)). No wrap is possible because compare-equal terminates counting.

## Timing
- E0 is the first edge sampling a stable valid vector with enablen=1. Outputs update at edge E0+DEBOUNCE_CYCLES; with the default, D, validn and key_strobe change after E16.
- key_strobe is high for exactly one cycle at acceptance, then again at E0+DEBOUNCE_CYCLES+k·REPEAT_CYCLES (k≥1) while the key is held.
- validn rises at the first edge where keypad≠ref while PRESSED.
- Earliest re-acceptance: DEBOUNCE_CYCLES edges of all-zero in RELEASE, then a full DEBOUNCE from IDLE.
- Simultaneous events: enablen=0 overrides everything. rst overrides enablen. A change during DEBOUNCE restarts from IDLE, so the new vector is re-evaluated the following edge.
- Outputs are registered; there is no combinational path from keypad to any output.

## Structure
- Package keypad_pkg: state enum (IDLE, DEBOUNCE, PRESSED, RELEASE), code-mapping function idx_to_code, clog2-based width constants.
- Sub-module keypad_prio_core: combinational NUM_KEYS→(code, cand_ok) resolver parametrised by MULTI_MODE. The FSM, counters and output registers live in keypad_encoder.

## Test plan
- Defaults; keypad=10'b0000100000 held 20 cycles → at E16: D=5, validn=0, one-cycle key_strobe; release → validn=1 next edge.
- Bounce: 10'b0000000010 for 5 cycles, 0 for 1 cycle, then stable → no strobe until 16 stable cycles after the last change; then D=9.
- MULTI_MODE=0, keypad=10'b1000000100 → validn stays 1, no strobe. MULTI_MODE=1, same vector → D=1 at E16.
- REPEAT_CYCLES=8, key 0 (bit0) held 40 cycles → strobes at E16, E24, E32, E40 with D=0 throughout.
- Key 3 in PRESSED, then enablen=0 → validn=1 next edge, busy=0, D stays 3. enablen=1 with key still held → fresh 16-cycle debounce, then strobe.
- rst asserted mid-DEBOUNCE and mid-PRESSED → next edge: D=0, validn=1, key_strobe=0, busy=0. NUM_KEYS=16, CODE_W=4: bit15 → D=1, bit1 → D=15.
